// File: rtl/jk_pkg.sv
// Shared types and JK excitation codes for the JK bank driver.
// Codes are packed as {j, k}.
package jk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      DRIVE = 2'b01,
      WAIT  = 2'b10,
      CHECK = 2'b11
   } state_t;

   localparam logic [1:0] JK_HOLD   = 2'b00;
   localparam logic [1:0] JK_RESET  = 2'b01;
   localparam logic [1:0] JK_SET    = 2'b10;
   localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_excite.sv
// One-bit JK excitation: current q and target t -> {j, k}.
// Define JK_TOGGLE_EN to drive every changing bit with the toggle code instead of set/reset.
module jk_excite
   import jk_pkg::*;
(
   input  logic       q,
   input  logic       t,
   output logic [1:0] jk
);

`ifdef JK_TOGGLE_EN
   localparam logic [1:0] JK_UP_C   = JK_TOGGLE;
   localparam logic [1:0] JK_DOWN_C = JK_TOGGLE;
`else
   localparam logic [1:0] JK_UP_C   = JK_SET;
   localparam logic [1:0] JK_DOWN_C = JK_RESET;
`endif

   // Unknown q falls to hold; the mismatch is caught later at the check.
   always_comb begin
      jk = JK_HOLD;
      case ({q, t})
         2'b01:   jk = JK_UP_C;
         2'b10:   jk = JK_DOWN_C;
         default: jk = JK_HOLD;
      endcase
   end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a bank of JK flip-flops to a target word, verifies q after settling, retries or flags err.
// Optional toggle excitation is selected by the JK_TOGGLE_EN macro (see jk_excite).
module jk_bank_driver
   import jk_pkg::*;
#(
   parameter int WIDTH         = 4,
   parameter int SETTLE_CYCLES = 1,
   parameter int MAX_RETRY     = 2
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tgt_valid,
   output logic             tgt_ready,
   input  logic [WIDTH-1:0] tgt_data,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] q_fb,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
   localparam logic [2:0] RETRY_MAX   = 3'(MAX_RETRY);

   state_t           state_r, state_s;
   logic [WIDTH-1:0] tgt_r, tgt_s;
   logic [WIDTH-1:0] j_r, j_s, k_r, k_s;
   logic [WIDTH-1:0] t_sel_s, ex_j_s, ex_k_s;
   logic [3:0]       cnt_r, cnt_s;
   logic [2:0]       retry_r, retry_s;
   logic             tgt_ready_r, tgt_ready_s;
   logic             busy_r;
   logic             done_r, done_s;
   logic             err_r, err_s;

   // On accept the target comes straight from the port; on retry from the latched copy.
   assign t_sel_s = (state_r == IDLE) ? tgt_data : tgt_r;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [1:0] jk_s;
      jk_excite u_excite (
         .q  (q_fb[gi]),
         .t  (t_sel_s[gi]),
         .jk (jk_s)
      );
      assign ex_j_s[gi] = jk_s[1];
      assign ex_k_s[gi] = jk_s[0];
   end

   // Next-state, excitation and handshake decode.
   always_comb begin
      state_s     = state_r;
      tgt_s       = tgt_r;
      j_s         = j_r;
      k_s         = k_r;
      cnt_s       = cnt_r;
      retry_s     = retry_r;
      tgt_ready_s = tgt_ready_r;
      done_s      = 1'b0;
      err_s       = 1'b0;
      case (state_r)
         IDLE: begin
            j_s = {WIDTH{1'b0}};
            k_s = {WIDTH{1'b0}};
            if (tgt_valid && tgt_ready_r) begin
               tgt_s       = tgt_data;
               j_s         = ex_j_s;
               k_s         = ex_k_s;
               retry_s     = 3'd0;
               tgt_ready_s = 1'b0;
               state_s     = DRIVE;
            end else begin
               tgt_ready_s = 1'b1;
               state_s     = IDLE;
            end
         end
         DRIVE: begin
            j_s     = {WIDTH{1'b0}};
            k_s     = {WIDTH{1'b0}};
            cnt_s   = SETTLE_LOAD;
            state_s = WAIT;
         end
         WAIT: begin
            if (cnt_r == 4'd0) begin
               state_s = CHECK;
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end
         CHECK: begin
            // An X on q_fb makes this compare unknown, which takes the mismatch path.
            if (q_fb == tgt_r) begin
               done_s      = 1'b1;
               tgt_ready_s = 1'b1;
               state_s     = IDLE;
            end else if (retry_r < RETRY_MAX) begin
               retry_s = retry_r + 3'd1;
               j_s     = ex_j_s;
               k_s     = ex_k_s;
               state_s = DRIVE;
            end else begin
               err_s       = 1'b1;
               tgt_ready_s = 1'b1;
               state_s     = IDLE;
            end
         end
         default: begin
            j_s         = {WIDTH{1'b0}};
            k_s         = {WIDTH{1'b0}};
            tgt_ready_s = 1'b0;
            state_s     = IDLE;
         end
      endcase
   end

   // State and output registers; reset parks the bank with j=k=0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         tgt_r       <= {WIDTH{1'b0}};
         j_r         <= {WIDTH{1'b0}};
         k_r         <= {WIDTH{1'b0}};
         cnt_r       <= 4'd0;
         retry_r     <= 3'd0;
         tgt_ready_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         state_r     <= state_s;
         tgt_r       <= tgt_s;
         j_r         <= j_s;
         k_r         <= k_s;
         cnt_r       <= cnt_s;
         retry_r     <= retry_s;
         tgt_ready_r <= tgt_ready_s;
         busy_r      <= (state_s != IDLE);
         done_r      <= done_s;
         err_r       <= err_s;
      end
   end

   assign tgt_ready = tgt_ready_r;
   assign j         = j_r;
   assign k         = k_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign err       = err_r;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench: jk_bank_driver driving a modelled 4-bit JK flip-flop bank.
// Expected excitation follows JK_TOGGLE_EN when that macro is defined.
module tb_jk_bank_driver;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       tgt_valid = 1'b0;
   logic       tgt_ready;
   logic [3:0] tgt_data = 4'b0000;
   logic [3:0] j, k, q_fb;
   logic [3:0] bank_q;
   logic [3:0] stuck_mask = 4'b0000;
   logic       busy, done, err;
   int         checks = 0;
   int         errors = 0;

`ifdef JK_TOGGLE_EN
   localparam logic [3:0] T3_J  = 4'b1100, T3_K  = 4'b1100;
   localparam logic [3:0] T4_J0 = 4'b0111, T4_K0 = 4'b0111;
   localparam logic [3:0] T4_JR = 4'b0001, T4_KR = 4'b0001;
   localparam logic [3:0] T5_J  = 4'b1111, T5_K  = 4'b1111;
`else
   localparam logic [3:0] T3_J  = 4'b0100, T3_K  = 4'b1000;
   localparam logic [3:0] T4_J0 = 4'b0001, T4_K0 = 4'b0110;
   localparam logic [3:0] T4_JR = 4'b0001, T4_KR = 4'b0000;
   localparam logic [3:0] T5_J  = 4'b1100, T5_K  = 4'b0011;
`endif

   jk_bank_driver dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tgt_valid (tgt_valid),
      .tgt_ready (tgt_ready),
      .tgt_data  (tgt_data),
      .j         (j),
      .k         (k),
      .q_fb      (q_fb),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Bank of JK flip-flops; stuck_mask forces feedback bits low.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_q <= 4'b0000;
      end else begin
         for (int i = 0; i < 4; i++) begin
            case ({j[i], k[i]})
               2'b01:   bank_q[i] <= 1'b0;
               2'b10:   bank_q[i] <= 1'b1;
               2'b11:   bank_q[i] <= ~bank_q[i];
               default: bank_q[i] <= bank_q[i];
            endcase
         end
      end
   end

   assign q_fb = bank_q & ~stuck_mask;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
      chk("done_err_excl", {3'b000, done & err}, 4'b0000);
`ifndef JK_TOGGLE_EN
      chk("no_jk_11", j & k, 4'b0000);
`endif
   endtask

   task automatic accept(input logic [3:0] data);
      tgt_valid = 1'b1;
      tgt_data  = data;
      step();
      tgt_valid = 1'b0;
      tgt_data  = ~data;
   endtask

   initial begin
      // 1: reset values, release, and reset in the middle of DRIVE
      #1 rst_n = 1'b0;
      #2;
      chk("rst_j", j, 4'b0000);
      chk("rst_k", k, 4'b0000);
      chk("rst_ready", {3'b000, tgt_ready}, 4'b0000);
      chk("rst_busy_done_err", {1'b0, busy, done, err}, 4'b0000);
      #9 rst_n = 1'b1;
      step();
      chk("ready_after_rel", {3'b000, tgt_ready}, 4'b0001);
      accept(4'b1010);
      chk("t1_drive_j", j, 4'b1010);
      chk("t1_drive_busy", {2'b00, busy, tgt_ready}, 4'b0010);
      #2 rst_n = 1'b0;
      #1;
      chk("t1_midrst_j", j, 4'b0000);
      chk("t1_midrst_k", k, 4'b0000);
      chk("t1_midrst_flags", {busy, tgt_ready, done, err}, 4'b0000);
      #2 rst_n = 1'b1;
      step();
      chk("t1_ready_rel", {busy, tgt_ready, done, err}, 4'b0100);
      chk("t1_bank", q_fb, 4'b0000);

      // 2: set bits 0000 -> 1010
      accept(4'b1010);
      chk("t2_j", j, 4'b1010);
      chk("t2_k", k, 4'b0000);
      step();
      chk("t2_e1_j", j, 4'b0000);
      chk("t2_e1_q", q_fb, 4'b1010);
      chk("t2_e1_flags", {busy, tgt_ready, done, err}, 4'b1000);
      step();
      chk("t2_e2_flags", {busy, tgt_ready, done, err}, 4'b1000);
      step();
      chk("t2_e3_flags", {busy, tgt_ready, done, err}, 4'b0110);
      step();
      chk("t2_e4_flags", {busy, tgt_ready, done, err}, 4'b0100);

      // 3: mixed change 1010 -> 0110
      accept(4'b0110);
      chk("t3_j", j, T3_J);
      chk("t3_k", k, T3_K);
      step();
      step();
      chk("t3_e2_done", {3'b000, done}, 4'b0000);
      step();
      chk("t3_e3_flags", {busy, tgt_ready, done, err}, 4'b0110);
      chk("t3_q", q_fb, 4'b0110);

      // 4: q_fb[0] stuck low, target 0001 -> two retries then err
      stuck_mask = 4'b0001;
      accept(4'b0001);
      chk("t4_d0_j", j, T4_J0);
      chk("t4_d0_k", k, T4_K0);
      for (int r = 0; r < 2; r++) begin
         step();
         step();
         step();
         chk("t4_retry_j", j, T4_JR);
         chk("t4_retry_k", k, T4_KR);
         chk("t4_retry_flags", {busy, tgt_ready, done, err}, 4'b1000);
      end
      step();
      step();
      chk("t4_e8_flags", {busy, tgt_ready, done, err}, 4'b1000);
      step();
      chk("t4_e9_flags", {busy, tgt_ready, done, err}, 4'b0101);
      step();
      chk("t4_e10_flags", {busy, tgt_ready, done, err}, 4'b0100);
      stuck_mask = 4'b0000;
      #1;
      chk("t4_bank", q_fb, 4'b0001);

      // 5: back-to-back 0011 then 1100 with tgt_valid held
      tgt_valid = 1'b1;
      tgt_data  = 4'b0011;
      step();
      tgt_data = 4'b1100;
      step();
      step();
      chk("t5_busy_ignored", {busy, tgt_ready, done, err}, 4'b1000);
      step();
      chk("t5_done1", {busy, tgt_ready, done, err}, 4'b0110);
      chk("t5_q1", q_fb, 4'b0011);
      step();
      tgt_valid = 1'b0;
      chk("t5_acc2_j", j, T5_J);
      chk("t5_acc2_k", k, T5_K);
      chk("t5_acc2_flags", {busy, tgt_ready, done, err}, 4'b1000);
      step();
      step();
      chk("t5_e6_done", {3'b000, done}, 4'b0000);
      step();
      chk("t5_done2", {busy, tgt_ready, done, err}, 4'b0110);
      chk("t5_q2", q_fb, 4'b1100);

      // 6: move to 0101, then target equal to current q
      step();
      accept(4'b0101);
      step();
      step();
      step();
      chk("t6_pre_done", {3'b000, done}, 4'b0001);
      chk("t6_pre_q", q_fb, 4'b0101);
      accept(4'b0101);
      chk("t6_j", j, 4'b0000);
      chk("t6_k", k, 4'b0000);
      chk("t6_busy", {3'b000, busy}, 4'b0001);
      step();
      chk("t6_e1_jk", j | k, 4'b0000);
      step();
      step();
      chk("t6_done", {busy, tgt_ready, done, err}, 4'b0110);
      chk("t6_q", q_fb, 4'b0101);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
